delay_mem_ctrl: RTL
===================

DELAY_MEM_CTRL -- requirements
Module: delay_mem_ctrl

Interface
REQ-001 The block SHALL have parameter data_width, default 16, giving the sample word width.
REQ-002 The block SHALL have parameter memory_size, default 8192, giving the word count; it SHALL be a power of two, and addr_width = clog2(memory_size).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-004 The ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear_req  in  1  one-cycle pulse requesting that all memory be zeroed
- write_req  in  1  level write request, held until write_ack
- write_addr  in  addr_width  write address
- write_data  in  data_width  signed write word
- write_ack  out  1  one-cycle write-done pulse
- read_req  in  1  level read request, held until read_valid
- read_addr  in  addr_width  read address
- read_data  out  data_width  signed read word
- read_valid  out  1  one-cycle read-data-valid pulse
- ready  out  1  high when no clear sweep is in progress

Function
REQ-005 Storage SHALL be one synchronous RAM of memory_size x data_width with a single write port and a single registered read port.
REQ-006 The state machine SHALL have exactly four states: CLEAR, IDLE, READ_1 and READ_2.
REQ-007 CLEAR behaviour:
- writes 0 to clear_addr every cycle
- clear_addr increments 0 -> memory_size-1
- after the write to memory_size-1, next state is IDLE
- the sweep lasts exactly memory_size cycles
- ready is 0 throughout
REQ-008 The block SHALL hold per-channel flags write_done and read_done.
- Set on ack/valid.
- Cleared on any cycle where the matching req is sampled low.
- A request is accepted only when req = 1 and its done flag = 0.
- This guarantees one service per request, even though the requester drops req one cycle after the ack.
REQ-009 IDLE with an acceptable write:
- RAM[write_addr] <= write_data
- write_ack = 1 on the following cycle
- write_done set
- state stays IDLE
REQ-010 IDLE with an acceptable read and no acceptable write:
- latch read_addr
- go READ_1 (RAM read issued)
- then READ_2 (output registered into read_data)
- read_valid = 1 in the cycle after READ_2
- return to IDLE
- total latency is 3 cycles from the accept edge to read_valid
REQ-011 When write and read are both acceptable in the same cycle, the write SHALL win; the read SHALL be accepted on the next IDLE cycle, so a same-address read returns the new word.
REQ-012 A write request arriving during READ_1 or READ_2 SHALL wait until IDLE and SHALL NOT be dropped.
REQ-013 The block SHALL accept at most one transaction per cycle and SHALL have at most one read in flight.
REQ-014 read_data SHALL hold its last value between reads.
REQ-015 write_ack and read_valid SHALL each be high for exactly one cycle per serviced request and SHALL never be high for a request not held at acceptance.
REQ-016 clear_req sampled in IDLE SHALL enter CLEAR next cycle, taking priority over pending requests, and SHALL clear both done flags.
REQ-017 clear_req sampled during READ_1 or READ_2 SHALL be latched and SHALL start CLEAR upon return to IDLE, after read_valid.
REQ-018 clear_req sampled during CLEAR SHALL be ignored.
REQ-019 Requests held during CLEAR SHALL NOT be acknowledged; they SHALL be serviced in order (write first) once IDLE is reached.
REQ-020 Address widths equal addr_width, so no out-of-range access exists; no bounds check is required.

Reset
REQ-021 On reset the block SHALL set:
- state = CLEAR, clear_addr = 0
- write_ack = 0, read_valid = 0, ready = 0
- read_data = 0
- write_done = 0, read_done = 0, pending-clear latch = 0
REQ-022 Reset asserted mid-read SHALL abort the read with no read_valid pulse; reset asserted mid-clear SHALL restart the sweep at address 0.
REQ-023 RAM contents SHALL NOT be reset directly; zeroing SHALL come only from the CLEAR sweep.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset released, memory_size = 16 -> ready rises after exactly 16 cycles; reads of addresses 0..15 return 0.
- Write addr 5 = 0x7FFF, req held until ack, then dropped one cycle later -> exactly one write_ack; a read of addr 5 returns 0x7FFF three cycles after accept.
- write_req (addr 3 = -2) and read_req (addr 3) asserted together -> write_ack first; read_valid later with read_data = 0xFFFE.
- read_req held for 6 cycles after read_valid while the requester is slow to drop it -> exactly one read_valid pulse.
- clear_req pulsed during READ_1 -> read_valid delivered; ready falls the next cycle; memory reads back 0 after the sweep.
- Reset pulsed at clear_addr = 7 -> sweep restarts at 0; ready rises memory_size cycles after reset release.

Source files
------------

// File: rtl/delay_mem_ctrl_if.sv
// Request/response bundle for delay_mem_ctrl: a write channel, a read channel,
// a clear pulse and the ready status, all in the clk domain of the controller.
interface delay_mem_ctrl_if #(
   parameter int data_width  = 16,
   parameter int memory_size = 8192
);
   localparam int addr_width = $clog2(memory_size);

   logic                         clear_req;
   logic                         write_req;
   logic        [addr_width-1:0] write_addr;
   logic signed [data_width-1:0] write_data;
   logic                         write_ack;
   logic                         read_req;
   logic        [addr_width-1:0] read_addr;
   logic signed [data_width-1:0] read_data;
   logic                         read_valid;
   logic                         ready;

   modport master (
      output clear_req, write_req, write_addr, write_data, read_req, read_addr,
      input  write_ack, read_data, read_valid, ready
   );

   modport slave (
      input  clear_req, write_req, write_addr, write_data, read_req, read_addr,
      output write_ack, read_data, read_valid, ready
   );
endinterface

// File: rtl/delay_mem_ctrl.sv
// Delay-line sample memory controller: single-port-write / registered-read RAM
// with a full zeroing sweep after reset or on request, and held-level handshakes.
module delay_mem_ctrl #(
   parameter int data_width  = 16,
   parameter int memory_size = 8192
) (
   input  logic            clk,
   input  logic            reset,
   delay_mem_ctrl_if.slave bus
);
   localparam int addr_width = $clog2(memory_size);
   localparam logic [addr_width-1:0] last_addr = addr_width'(memory_size - 1);
   localparam logic [addr_width-1:0] addr_one  = addr_width'(1);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_IDLE   = 2'd1,
      S_READ_1 = 2'd2,
      S_READ_2 = 2'd3
   } state_t;

   state_t                       r_state;
   logic        [addr_width-1:0] r_clear_addr;
   logic        [addr_width-1:0] r_read_addr;
   logic signed [data_width-1:0] r_mem [memory_size];
   logic signed [data_width-1:0] r_ram_q;
   logic signed [data_width-1:0] r_read_data;
   logic                         r_write_ack;
   logic                         r_read_valid;
   logic                         r_ready;
   logic                         r_write_done;
   logic                         r_read_done;
   logic                         r_clear_pend;

   logic                         w_write_ok;
   logic                         w_read_ok;
   logic                         w_clear_go;
   logic                         w_ram_we;
   logic        [addr_width-1:0] w_ram_waddr;
   logic signed [data_width-1:0] w_ram_wdata;

   // A done flag blocks re-service of a request the requester has not yet dropped.
   assign w_write_ok = bus.write_req & ~r_write_done;
   assign w_read_ok  = bus.read_req & ~r_read_done;
   assign w_clear_go = bus.clear_req | r_clear_pend;

   assign bus.write_ack  = r_write_ack;
   assign bus.read_valid = r_read_valid;
   assign bus.read_data  = r_read_data;
   assign bus.ready      = r_ready;

   // RAM write-port steering: sweep zeros in CLEAR, requester data in IDLE.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_waddr = r_clear_addr;
      w_ram_wdata = {data_width{1'b0}};
      if (reset) begin
         w_ram_we = 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               w_ram_we    = 1'b1;
               w_ram_waddr = r_clear_addr;
               w_ram_wdata = {data_width{1'b0}};
            end
            S_IDLE: begin
               if (!w_clear_go && w_write_ok) begin
                  w_ram_we    = 1'b1;
                  w_ram_waddr = bus.write_addr;
                  w_ram_wdata = bus.write_data;
               end else begin
                  w_ram_we = 1'b0;
               end
            end
            default: begin
               w_ram_we = 1'b0;
            end
         endcase
      end
   end

   // Sample storage; contents are only ever zeroed by the sweep, never by reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_mem[w_ram_waddr] <= w_ram_wdata;
      end
      if (r_state == S_READ_1) begin
         r_ram_q <= r_mem[r_read_addr];
      end
   end

   // Controller FSM with registered handshake outputs and done flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_CLEAR;
         r_clear_addr <= {addr_width{1'b0}};
         r_read_addr  <= {addr_width{1'b0}};
         r_read_data  <= {data_width{1'b0}};
         r_write_ack  <= 1'b0;
         r_read_valid <= 1'b0;
         r_ready      <= 1'b0;
         r_write_done <= 1'b0;
         r_read_done  <= 1'b0;
         r_clear_pend <= 1'b0;
      end else begin
         r_write_ack  <= 1'b0;
         r_read_valid <= 1'b0;
         if (!bus.write_req) begin
            r_write_done <= 1'b0;
         end
         if (!bus.read_req) begin
            r_read_done <= 1'b0;
         end

         case (r_state)
            S_CLEAR: begin
               r_ready      <= 1'b0;
               r_clear_addr <= r_clear_addr + addr_one;
               if (r_clear_addr == last_addr) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_clear_go) begin
                  r_state      <= S_CLEAR;
                  r_clear_addr <= {addr_width{1'b0}};
                  r_ready      <= 1'b0;
                  r_clear_pend <= 1'b0;
                  r_write_done <= 1'b0;
                  r_read_done  <= 1'b0;
               end else if (w_write_ok) begin
                  r_write_ack  <= 1'b1;
                  r_write_done <= 1'b1;
               end else if (w_read_ok) begin
                  r_read_addr <= bus.read_addr;
                  r_state     <= S_READ_1;
               end
            end
            S_READ_1: begin
               if (bus.clear_req) begin
                  r_clear_pend <= 1'b1;
               end
               r_state <= S_READ_2;
            end
            S_READ_2: begin
               // A clear seen here waits one IDLE cycle so read_valid goes out first.
               if (bus.clear_req) begin
                  r_clear_pend <= 1'b1;
               end
               r_read_data  <= r_ram_q;
               r_read_valid <= 1'b1;
               r_read_done  <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state      <= S_CLEAR;
               r_clear_addr <= {addr_width{1'b0}};
               r_ready      <= 1'b0;
            end
         endcase
      end
   end
endmodule
